// File: rtl/grid_access_arbiter.sv
// grid_access_arbiter: shares the single-port game-grid RAM between the arena
// rebuild sequencer, the VGA renderer (read-only, priority) and the game engine
// (read/write, with a starvation override).
// Optional feature macro: GRID_WRITE_PROTECT_EN. When defined, game writes to
// border cells are granted but suppressed at the RAM, and protect_hit pulses.
module grid_access_arbiter #(
  parameter int unsigned GRID_SIZE     = 16,
  parameter int unsigned LOG_GRID_SIZE = 4,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear_start,
  output logic                       clear_busy,
  output logic                       clear_done,
  input  logic                       vga_req,
  input  logic [2*LOG_GRID_SIZE-1:0] vga_addr,
  output logic                       vga_gnt,
  output logic                       vga_rvalid,
  output logic                       vga_rdata,
  input  logic                       game_req,
  input  logic                       game_we,
  input  logic [2*LOG_GRID_SIZE-1:0] game_addr,
  input  logic                       game_wdata,
  output logic                       game_gnt,
  output logic                       game_rvalid,
  output logic                       game_rdata,
  output logic                       ram_en,
  output logic                       ram_we,
  output logic [2*LOG_GRID_SIZE-1:0] ram_addr,
  output logic                       ram_wdata,
  input  logic                       ram_rdata,
  output logic                       protect_hit
);

  localparam int unsigned AW = 2 * LOG_GRID_SIZE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [AW-1:0]   clr_cnt;
  logic [3:0]      wait_cnt;
  logic            busy_q;
  logic            done_q;
  logic            vga_rd_q;
  logic            game_rd_q;
  logic            idle;
  logic            starve;
  logic            game_win;
  logic            game_wr_blocked;

  // A cell is on the border when either coordinate is at 0 or GRID_SIZE-1.
  function automatic logic is_border(input logic [AW-1:0] a);
    logic [LOG_GRID_SIZE-1:0] x;
    logic [LOG_GRID_SIZE-1:0] y;
    x = a[LOG_GRID_SIZE-1:0];
    y = a[AW-1:LOG_GRID_SIZE];
    return (x == '0) || (x == LOG_GRID_SIZE'(GRID_SIZE - 1)) ||
           (y == '0) || (y == LOG_GRID_SIZE'(GRID_SIZE - 1));
  endfunction

  // Rebuild sequencer: IDLE -> CLEAR (one write per cell) -> DONE -> IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      clr_cnt <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_start) begin
            state   <= CLEAR;
            busy_q  <= 1'b1;
            clr_cnt <= '0;
          end
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + AW'(1);
          if (clr_cnt == '1) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign clear_busy = busy_q;
  assign clear_done = done_q;

  // Arbitration: VGA first unless the game has waited STARVE_LIMIT cycles.
  always_comb begin
    idle     = (state == IDLE);
    starve   = (wait_cnt == 4'(STARVE_LIMIT));
    game_win = game_req && (!vga_req || starve);
    vga_gnt  = reset_n && idle && vga_req && !game_win;
    game_gnt = reset_n && idle && game_win;
  end

`ifdef GRID_WRITE_PROTECT_EN
  assign game_wr_blocked = game_gnt && game_we && is_border(game_addr);
`else
  assign game_wr_blocked = 1'b0;
`endif

  assign protect_hit = game_wr_blocked;

  // Starvation counter: frozen while the sequencer owns the RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (state == IDLE) begin
      if (!game_req || game_gnt) begin
        wait_cnt <= '0;
      end else if (wait_cnt != 4'(STARVE_LIMIT)) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end
  end

  // RAM port mux: sequencer in CLEAR, otherwise the granted requester.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = 1'b0;
    if (reset_n) begin
      if (state == CLEAR) begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = clr_cnt;
        ram_wdata = is_border(clr_cnt);
      end else if (vga_gnt) begin
        ram_en   = 1'b1;
        ram_addr = vga_addr;
      end else if (game_gnt) begin
        ram_en    = !game_wr_blocked;
        ram_we    = game_we && !game_wr_blocked;
        ram_addr  = game_addr;
        ram_wdata = game_wdata;
      end
    end
  end

  // Track read grants so data is steered back one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_rd_q  <= 1'b0;
      game_rd_q <= 1'b0;
    end else begin
      vga_rd_q  <= vga_gnt;
      game_rd_q <= game_gnt && !game_we;
    end
  end

  assign vga_rvalid  = vga_rd_q;
  assign vga_rdata   = vga_rd_q && ram_rdata;
  assign game_rvalid = game_rd_q;
  assign game_rdata  = game_rd_q && ram_rdata;

endmodule

// File: tb/tb_grid_access_arbiter.sv
// Directed bench for grid_access_arbiter with a behavioural synchronous RAM.
module tb_grid_access_arbiter;

  logic       clk;
  logic       reset_n;
  logic       clear_start;
  logic       clear_busy;
  logic       clear_done;
  logic       vga_req;
  logic [7:0] vga_addr;
  logic       vga_gnt;
  logic       vga_rvalid;
  logic       vga_rdata;
  logic       game_req;
  logic       game_we;
  logic [7:0] game_addr;
  logic       game_wdata;
  logic       game_gnt;
  logic       game_rvalid;
  logic       game_rdata;
  logic       ram_en;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic       ram_wdata;
  logic       ram_rdata;
  logic       protect_hit;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic mem [0:255];

  grid_access_arbiter #(
    .GRID_SIZE    (16),
    .LOG_GRID_SIZE(4),
    .STARVE_LIMIT (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear_start(clear_start),
    .clear_busy (clear_busy),
    .clear_done (clear_done),
    .vga_req    (vga_req),
    .vga_addr   (vga_addr),
    .vga_gnt    (vga_gnt),
    .vga_rvalid (vga_rvalid),
    .vga_rdata  (vga_rdata),
    .game_req   (game_req),
    .game_we    (game_we),
    .game_addr  (game_addr),
    .game_wdata (game_wdata),
    .game_gnt   (game_gnt),
    .game_rvalid(game_rvalid),
    .game_rdata (game_rdata),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .protect_hit(protect_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 1'b0;
    ram_rdata = 1'b0;
  end

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  int unsigned busy_cycles, writes, rd_in_clear, grants, dones, done_at;
  logic [1:0]  w00, w11, w1f, wff, first_addr_ok;
  logic        found, seen_done, seen_busy;
  logic        exp_prot_hit, exp_ram_en, exp_ram_we, exp_border_rd;

  initial begin
    reset_n     = 1'b0;
    clear_start = 1'b0;
    vga_req     = 1'b1;
    vga_addr    = 8'h00;
    game_req    = 1'b1;
    game_we     = 1'b1;
    game_addr   = 8'h00;
    game_wdata  = 1'b1;

    // Reset: every output low even with requests asserted.
    repeat (2) @(negedge clk);
    #1;
    check("rst_vga_gnt",  32'(vga_gnt), 0);
    check("rst_game_gnt", 32'(game_gnt), 0);
    check("rst_ram_en",   32'(ram_en), 0);
    check("rst_ram_we",   32'(ram_we), 0);
    check("rst_busy",     32'(clear_busy), 0);
    check("rst_done",     32'(clear_done), 0);
    check("rst_rvalid",   32'({vga_rvalid, game_rvalid}), 0);
    check("rst_prot",     32'(protect_hit), 0);

    @(negedge clk);
    reset_n  = 1'b1;
    vga_req  = 1'b0;
    game_req = 1'b0;
    game_we  = 1'b0;

    // Read granted in the clear_start cycle still returns.
    @(negedge clk);
    clear_start = 1'b1;
    vga_req     = 1'b1;
    vga_addr    = 8'h22;
    #1;
    check("start_vga_gnt", 32'(vga_gnt), 1);
    @(negedge clk);
    clear_start = 1'b0;
    vga_req     = 1'b1;
    vga_addr    = 8'h11;
    game_req    = 1'b1;
    game_we     = 1'b0;
    game_addr   = 8'h00;
    #1;
    check("start_vga_rvalid", 32'(vga_rvalid), 1);

    // Rebuild: 257 busy cycles, 256 writes, one done pulse, no grants.
    busy_cycles = 0; writes = 0; rd_in_clear = 0; grants = 0; dones = 0; done_at = 0;
    w00 = 2'd2; w11 = 2'd2; w1f = 2'd2; wff = 2'd2; first_addr_ok = 2'd2;
    for (int i = 0; i < 300; i++) begin
      if (i > 0) next_cycle();
      if (!clear_busy) break;
      busy_cycles++;
      if (i == 0) first_addr_ok = {1'b0, (ram_addr == 8'h00) && ram_we};
      if (ram_en && ram_we) begin
        writes++;
        case (ram_addr)
          8'h00: w00 = {1'b0, ram_wdata};
          8'h11: w11 = {1'b0, ram_wdata};
          8'h1F: w1f = {1'b0, ram_wdata};
          8'hFF: wff = {1'b0, ram_wdata};
          default: ;
        endcase
      end
      if (ram_en && !ram_we) rd_in_clear++;
      if (vga_gnt || game_gnt) grants++;
      if (clear_done) begin
        dones++;
        done_at = busy_cycles;
      end
    end
    check("clr_busy_cycles", busy_cycles, 257);
    check("clr_writes",      writes, 256);
    check("clr_reads",       rd_in_clear, 0);
    check("clr_grants",      grants, 0);
    check("clr_dones",       dones, 1);
    check("clr_done_at",     done_at, 257);
    check("clr_first_addr",  32'(first_addr_ok), 1);
    check("clr_w00",         32'(w00), 1);
    check("clr_w11",         32'(w11), 0);
    check("clr_w1f",         32'(w1f), 1);
    check("clr_wff",         32'(wff), 1);

    // Starvation: VGA x4, game on 5th, VGA again.
    for (int k = 0; k < 6; k++) begin
      if (k > 0) next_cycle();
      check($sformatf("stv_vga_gnt%0d", k),  32'(vga_gnt),  (k != 4) ? 1 : 0);
      check($sformatf("stv_game_gnt%0d", k), 32'(game_gnt), (k == 4) ? 1 : 0);
      if (k == 1) begin
        check("stv_vga_rvalid", 32'(vga_rvalid), 1);
        check("stv_vga_rdata",  32'(vga_rdata), 0);
      end
      if (k == 4) begin
        check("stv_ram_addr", 32'(ram_addr), 32'h00);
        check("stv_ram_we",   32'(ram_we), 0);
        check("stv_game_rvalid_early", 32'(game_rvalid), 0);
      end
      if (k == 5) begin
        check("stv_game_rvalid", 32'(game_rvalid), 1);
        check("stv_game_rdata",  32'(game_rdata), 1);
      end
    end

    // Game write then read of interior cell 0x55.
    @(negedge clk);
    vga_req    = 1'b0;
    game_req   = 1'b1;
    game_we    = 1'b1;
    game_addr  = 8'h55;
    game_wdata = 1'b1;
    #1;
    check("wr55_gnt",   32'(game_gnt), 1);
    check("wr55_en",    32'(ram_en), 1);
    check("wr55_we",    32'(ram_we), 1);
    check("wr55_addr",  32'(ram_addr), 32'h55);
    check("wr55_wdata", 32'(ram_wdata), 1);
    check("wr55_prot",  32'(protect_hit), 0);
    @(negedge clk);
    game_we = 1'b0;
    #1;
    check("wr55_no_rvalid", 32'(game_rvalid), 0);
    check("rd55_gnt",       32'(game_gnt), 1);
    check("rd55_we",        32'(ram_we), 0);
    @(negedge clk);
    game_req = 1'b0;
    #1;
    check("rd55_rvalid", 32'(game_rvalid), 1);
    check("rd55_rdata",  32'(game_rdata), 1);

    // Border write 0x0F with data 0.
`ifdef GRID_WRITE_PROTECT_EN
    exp_prot_hit = 1'b1; exp_ram_en = 1'b0; exp_ram_we = 1'b0; exp_border_rd = 1'b1;
`else
    exp_prot_hit = 1'b0; exp_ram_en = 1'b1; exp_ram_we = 1'b1; exp_border_rd = 1'b0;
`endif
    @(negedge clk);
    game_req   = 1'b1;
    game_we    = 1'b1;
    game_addr  = 8'h0F;
    game_wdata = 1'b0;
    #1;
    check("wr0f_gnt",  32'(game_gnt), 1);
    check("wr0f_prot", 32'(protect_hit), 32'(exp_prot_hit));
    check("wr0f_en",   32'(ram_en), 32'(exp_ram_en));
    check("wr0f_we",   32'(ram_we), 32'(exp_ram_we));
    @(negedge clk);
    game_we = 1'b0;
    #1;
    check("rd0f_gnt",  32'(game_gnt), 1);
    check("rd0f_prot", 32'(protect_hit), 0);
    @(negedge clk);
    game_req = 1'b0;
    #1;
    check("rd0f_rvalid", 32'(game_rvalid), 1);
    check("rd0f_rdata",  32'(game_rdata), 32'(exp_border_rd));

    // Reset during rebuild at counter 0x80.
    @(negedge clk);
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    #1;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (clear_busy && ram_en && ram_addr == 8'h80) begin
        found = 1'b1;
        break;
      end
      next_cycle();
    end
    check("mid_reach_80",  32'(found), 1);
    check("mid_wdata_80",  32'(ram_wdata), 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy",  32'(clear_busy), 0);
    check("mid_rst_en",    32'(ram_en), 0);
    check("mid_rst_we",    32'(ram_we), 0);
    check("mid_rst_addr",  32'(ram_addr), 0);
    check("mid_rst_wdata", 32'(ram_wdata), 0);
    check("mid_rst_done",  32'(clear_done), 0);
    @(negedge clk);
    reset_n = 1'b1;
    seen_done = 1'b0;
    seen_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      seen_done |= clear_done;
      seen_busy |= clear_busy | ram_en;
    end
    check("mid_no_done", 32'(seen_done), 0);
    check("mid_idle",    32'(seen_busy), 0);

    @(negedge clk);
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    #1;
    check("restart_addr", 32'(ram_addr), 32'h00);
    check("restart_we",   32'(ram_we), 1);
    check("restart_busy", 32'(clear_busy), 1);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      next_cycle();
      if (clear_done) found = 1'b1;
      if (!clear_busy) break;
    end
    check("restart_done", 32'(found), 1);
    check("restart_idle", 32'(clear_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
